// File: rtl/light_playback_sequencer_if.sv
// Signal bundle between the tail-light playback sequencer, its pattern ROM,
// the divider tick source and the manual-state decoder.
interface light_playback_sequencer_if #(
    parameter int ADDR_W  = 3,
    parameter int STATE_W = 4
);
    // tick is a one-clk pulse, sampled only at rising edges. The ROM has no valid
    // strobe: rom_q is trusted exactly ROM_LAT clks after rom_addr changes.
    logic               tick;
    logic               playback;
    logic               loop_en;
    logic               pause;
    logic [ADDR_W-1:0]  last_addr;
    logic [STATE_W-1:0] manual_state;
    logic [STATE_W-1:0] rom_q;
    logic [ADDR_W-1:0]  rom_addr;
    logic [STATE_W-1:0] state_out;
    logic               busy;
    logic               done;
    logic [1:0]         dbg_state;

    modport master (
        output tick, playback, loop_en, pause, last_addr, manual_state, rom_q,
        input  rom_addr, state_out, busy, done, dbg_state
    );

    modport slave (
        input  tick, playback, loop_en, pause, last_addr, manual_state, rom_q,
        output rom_addr, state_out, busy, done, dbg_state
    );
endinterface

// File: rtl/light_playback_sequencer.sv
// Plays tail-light states out of an 8-entry pattern ROM, each held for DWELL
// divider ticks, and muxes that playback against the manual light state.
module light_playback_sequencer #(
    parameter int ADDR_W  = 3,
    parameter int STATE_W = 4,
    parameter int DWELL   = 4,
    parameter int ROM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    light_playback_sequencer_if.slave io
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHOW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DW_W  = $clog2(DWELL + 1);
    localparam int LAT_W = $clog2(ROM_LAT + 1);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [LAT_W-1:0] LAT_LAST   = LAT_W'(ROM_LAT - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [STATE_W-1:0] out_q, out_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [LAT_W-1:0]   lat_q, lat_d;
    logic               busy_q, done_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            out_q   <= '0;
            dwell_q <= '0;
            lat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            dwell_q <= dwell_d;
            lat_q   <= lat_d;
            busy_q  <= (state_d == FETCH) || (state_d == SHOW);
            done_q  <= (state_d == DONE);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        out_d   = out_q;
        dwell_d = dwell_q;
        lat_d   = lat_q;

        // Dropping playback outranks everything else, including a coincident tick.
        if (state_q != IDLE && !io.playback) begin
            state_d = IDLE;
            addr_d  = '0;
            out_d   = io.manual_state;
            dwell_d = '0;
            lat_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    out_d = io.manual_state;
                    if (io.playback) begin
                        state_d = FETCH;
                        addr_d  = '0;
                        lat_d   = '0;
                    end
                end
                FETCH: begin
                    if (lat_q == LAT_LAST) begin
                        state_d = SHOW;
                        out_d   = io.rom_q;
                        dwell_d = '0;
                        lat_d   = '0;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                SHOW: begin
                    if (io.tick && !io.pause) begin
                        if (dwell_q == DWELL_LAST) begin
                            dwell_d = '0;
                            lat_d   = '0;
                            if (addr_q != io.last_addr) begin
                                addr_d  = addr_q + ADDR_W'(1);
                                state_d = FETCH;
                            end else if (io.loop_en) begin
                                addr_d  = '0;
                                state_d = FETCH;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            dwell_d = dwell_q + DW_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign io.rom_addr  = addr_q;
    assign io.state_out = out_q;
    assign io.busy      = busy_q;
    assign io.done      = done_q;
    assign io.dbg_state = state_q;
endmodule

// File: tb/tb_light_playback_sequencer.sv
// Directed bench for light_playback_sequencer with a one-cycle-latency ROM model.
module tb_light_playback_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [3:0] rom [8];

    light_playback_sequencer_if #(.ADDR_W(3), .STATE_W(4)) bus ();

    light_playback_sequencer #(
        .ADDR_W(3), .STATE_W(4), .DWELL(4), .ROM_LAT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM updates on the falling edge, so data is only valid one clk after the address moves.
    always @(negedge clk) bus.rom_q <= rom[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        repeat (9) step();
    endtask

    task automatic expect_show(input string tag, input int addr);
        check({tag, "_state"}, 32'(bus.state_out), 32'(rom[addr]));
        check({tag, "_addr"}, 32'(bus.rom_addr), 32'(addr));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rom = '{4'd1, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd2};
        rst              = 1'b0;
        bus.tick         = 1'b0;
        bus.playback     = 1'b0;
        bus.loop_en      = 1'b0;
        bus.pause        = 1'b0;
        bus.last_addr    = 3'd7;
        bus.manual_state = 4'b0101;

        // Reset, then manual pass-through
        step();
        step();
        check("rst_state_out", 32'(bus.state_out), 32'h0);
        check("rst_addr", 32'(bus.rom_addr), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        rst = 1'b1;
        step();
        check("manual_state_out", 32'(bus.state_out), 32'h5);
        check("manual_busy", 32'(bus.busy), 32'h0);
        check("manual_fsm", 32'(bus.dbg_state), 32'h0);

        // One-shot playback over all eight entries
        bus.playback = 1'b1;
        step();
        check("start_busy", 32'(bus.busy), 32'h1);
        check("start_fetch", 32'(bus.dbg_state), 32'h1);
        check("start_state_held", 32'(bus.state_out), 32'h5);
        step();
        for (int i = 0; i < 8; i++) begin
            expect_show($sformatf("oneshot%0d", i), i);
            repeat (3) do_tick();
            check($sformatf("oneshot%0d_hold", i), 32'(bus.state_out), 32'(rom[i]));
            bus.tick = 1'b1;
            step();
            bus.tick = 1'b0;
            check($sformatf("oneshot%0d_next_addr", i), 32'(bus.rom_addr), 32'((i < 7) ? i + 1 : 7));
            check($sformatf("oneshot%0d_lat_hold", i), 32'(bus.state_out), 32'(rom[i]));
            repeat (9) step();
        end
        check("oneshot_done", 32'(bus.done), 32'h1);
        check("oneshot_busy", 32'(bus.busy), 32'h0);
        check("oneshot_final_state", 32'(bus.state_out), 32'h2);
        check("oneshot_final_addr", 32'(bus.rom_addr), 32'h7);
        bus.loop_en = 1'b1;
        do_tick();
        do_tick();
        check("done_loop_toggle", 32'(bus.done), 32'h1);
        check("done_loop_addr", 32'(bus.rom_addr), 32'h7);

        // Leaving DONE by dropping playback
        bus.playback = 1'b0;
        step();
        check("done_abort_done", 32'(bus.done), 32'h0);
        check("done_abort_state", 32'(bus.state_out), 32'h5);
        check("done_abort_addr", 32'(bus.rom_addr), 32'h0);

        // Looping over entries 0..2
        bus.last_addr = 3'd2;
        bus.loop_en   = 1'b1;
        bus.playback  = 1'b1;
        step();
        step();
        for (int k = 0; k < 7; k++) begin
            expect_show($sformatf("loop%0d", k), k % 3);
            check($sformatf("loop%0d_done", k), 32'(bus.done), 32'h0);
            repeat (4) do_tick();
        end

        // A tick landing on the FETCH cycle is not counted
        expect_show("ftick_pre", 1);
        repeat (3) do_tick();
        bus.tick = 1'b1;
        step();
        check("ftick_in_fetch", 32'(bus.dbg_state), 32'h1);
        step();
        bus.tick = 1'b0;
        repeat (8) step();
        expect_show("ftick_show", 2);
        repeat (3) do_tick();
        check("ftick_three_later", 32'(bus.rom_addr), 32'h2);
        do_tick();
        expect_show("ftick_wrap", 0);

        // Pause freezes the dwell count
        repeat (4) do_tick();
        expect_show("pause_entry", 1);
        repeat (2) do_tick();
        bus.pause = 1'b1;
        for (int p = 0; p < 5; p++) begin
            do_tick();
            expect_show($sformatf("paused%0d", p), 1);
        end
        bus.pause = 1'b0;
        do_tick();
        expect_show("unpause_first", 1);
        do_tick();
        expect_show("unpause_second", 2);

        // last_addr widened mid-entry applies at the next end of dwell
        bus.last_addr = 3'd7;
        repeat (4) do_tick();
        expect_show("widen", 3);

        // Abort during SHOW at address 3
        bus.manual_state = 4'b1000;
        bus.playback     = 1'b0;
        step();
        check("abort_fsm", 32'(bus.dbg_state), 32'h0);
        check("abort_addr", 32'(bus.rom_addr), 32'h0);
        check("abort_state", 32'(bus.state_out), 32'h8);
        check("abort_busy", 32'(bus.busy), 32'h0);
        bus.playback = 1'b1;
        step();
        step();
        expect_show("restart", 0);

        // Abort beats a coincident tick
        bus.manual_state = 4'b0110;
        bus.tick         = 1'b1;
        bus.playback     = 1'b0;
        step();
        bus.tick = 1'b0;
        check("abort_tick_fsm", 32'(bus.dbg_state), 32'h0);
        check("abort_tick_state", 32'(bus.state_out), 32'h6);

        // Single-entry one-shot, then reset while DONE
        bus.last_addr = 3'd0;
        bus.loop_en   = 1'b0;
        bus.playback  = 1'b1;
        step();
        step();
        expect_show("single", 0);
        repeat (3) do_tick();
        check("single_not_done", 32'(bus.done), 32'h0);
        do_tick();
        check("single_done", 32'(bus.done), 32'h1);
        expect_show("single_final", 0);
        rst = 1'b0;
        step();
        check("rst_done_state", 32'(bus.state_out), 32'h0);
        check("rst_done_done", 32'(bus.done), 32'h0);
        check("rst_done_busy", 32'(bus.busy), 32'h0);
        check("rst_done_addr", 32'(bus.rom_addr), 32'h0);
        rst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
